// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Purpose  : Valid/ready read port of the UART receive FIFO (head entry + flags).
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 rd_valid;
    logic                 rd_ready;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_perr;
    logic                 rd_ferr;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_perr,
        output rd_ferr,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_perr,
        input  rd_ferr,
        output rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Oversampling UART receiver (5-9 data bits, opt. parity, 1/2 stop)
//            feeding a power-of-two FIFO with per-frame parity/framing flags.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic                        rx,
    uart_rx_fifo_if.master              rd_if,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    input  logic                        clear_ovf,
    output logic                        busy
);
    localparam int               c_AW      = $clog2(FIFO_DEPTH);
    localparam int               c_BIT_W   = $clog2(DATA_BITS);
    localparam int               c_WORD_W  = DATA_BITS + 2;
    localparam logic             c_PAR_ODD = (PARITY == 1);
    localparam logic [c_AW:0]    c_FULL    = {1'b1, {c_AW{1'b0}}};
    localparam logic [DIV_W-1:0] c_DIV_MIN = DIV_W'(4);

    typedef enum logic [2:0] {
        S_BREAK  = 3'd0,
        S_IDLE   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                 r_rx_meta;
    logic                 r_rx_s;
    state_t               r_state,     w_state_nxt;
    logic [DIV_W-1:0]     r_div_l,     w_div_nxt;
    logic [DIV_W-1:0]     r_cnt,       w_cnt_nxt;
    logic [c_BIT_W-1:0]   r_bit_idx,   w_bit_nxt;
    logic                 r_stop_idx,  w_stop_nxt;
    logic [DATA_BITS-1:0] r_shift,     w_shift_nxt;
    logic                 r_perr,      w_perr_nxt;
    logic                 r_ferr,      w_ferr_nxt;
    logic                 r_push,      w_push;
    logic [c_WORD_W-1:0]  r_push_word, w_push_word;
    logic [DIV_W-1:0]     w_div_eff;

    assign w_div_eff = (cfg_div < c_DIV_MIN) ? c_DIV_MIN : cfg_div;

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_l;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_stop_nxt  = r_stop_idx;
        w_shift_nxt = r_shift;
        w_perr_nxt  = r_perr;
        w_ferr_nxt  = r_ferr;
        w_push      = 1'b0;
        w_push_word = '0;
        case (r_state)
            S_BREAK: begin
                if (r_rx_s) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!r_rx_s) begin
                    // First sample lands mid start bit, then one per bit period.
                    w_div_nxt   = w_div_eff;
                    w_cnt_nxt   = (w_div_eff >> 1) - DIV_W'(1);
                    w_bit_nxt   = '0;
                    w_stop_nxt  = 1'b0;
                    w_perr_nxt  = 1'b0;
                    w_ferr_nxt  = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START, S_DATA, S_PARITY, S_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DIV_W'(1);
                end else begin
                    w_cnt_nxt = r_div_l - DIV_W'(1);
                    case (r_state)
                        S_START: begin
                            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                            w_bit_nxt   = '0;
                        end
                        S_DATA: begin
                            w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                            if (r_bit_idx == c_BIT_W'(DATA_BITS - 1))
                                w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                            else
                                w_bit_nxt = r_bit_idx + c_BIT_W'(1);
                        end
                        S_PARITY: begin
                            w_perr_nxt  = ((^r_shift) ^ r_rx_s) != c_PAR_ODD;
                            w_state_nxt = S_STOP;
                        end
                        default: begin
                            w_ferr_nxt = r_ferr | ~r_rx_s;
                            if ((STOP_BITS == 1) || r_stop_idx) begin
                                w_push      = 1'b1;
                                w_push_word = {w_ferr_nxt, r_perr, r_shift};
                                // A low stop bit may be a line break: wait for idle.
                                w_state_nxt = w_ferr_nxt ? S_BREAK : S_IDLE;
                            end else begin
                                w_stop_nxt = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: w_state_nxt = S_BREAK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_state     <= S_BREAK;
            r_div_l     <= '0;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
        end else begin
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
            r_state     <= w_state_nxt;
            r_div_l     <= w_div_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_stop_idx  <= w_stop_nxt;
            r_shift     <= w_shift_nxt;
            r_perr      <= w_perr_nxt;
            r_ferr      <= w_ferr_nxt;
            r_push      <= w_push;
            r_push_word <= w_push_word;
        end
    end

    assign busy = (r_state == S_START) || (r_state == S_DATA) ||
                  (r_state == S_PARITY) || (r_state == S_STOP);

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic                r_overflow;
    logic [c_AW:0]       w_level;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_wr_en;
    logic [c_WORD_W-1:0] w_head;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == c_FULL);
    assign w_empty = (w_level == '0);
    assign w_pop   = ~w_empty & rd_if.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr_en = r_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_push & w_full & ~w_pop)
                r_overflow <= 1'b1;
            else if (clear_ovf)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= r_push_word;
    end

    assign w_head         = r_mem[r_rd_ptr[c_AW-1:0]];
    assign level          = w_level;
    assign overflow       = r_overflow;
    assign rd_if.rd_valid = ~w_empty;
    assign rd_if.rd_data  = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign rd_if.rd_perr  = ~w_empty & w_head[DATA_BITS] & (PARITY != 0);
    assign rd_if.rd_ferr  = ~w_empty & w_head[DATA_BITS+1];

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed self-checking bench for uart_rx_fifo over four configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    logic        clk = 1'b0;
    logic [3:0]  rst_v;
    logic [3:0]  rx_v;
    logic [3:0]  clr_v;
    logic [15:0] cfg_div;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    // ch0: 8N1 depth16, ch1: 8E1, ch2: 8N1 depth4, ch3: 9N2
    logic [4:0] level_a, level_p, level_9;
    logic [2:0] level_f;
    logic       ovf_a, ovf_p, ovf_f, ovf_9;
    logic       busy_a, busy_p, busy_f, busy_9;

    uart_rx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if_p ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if_f ();
    uart_rx_fifo_if #(.DATA_BITS(9)) if_9 ();

    uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16), .DIV_W(16)) u_a (
        .clk(clk), .reset(rst_v[0]), .cfg_div(cfg_div), .rx(rx_v[0]), .rd_if(if_a),
        .level(level_a), .overflow(ovf_a), .clear_ovf(clr_v[0]), .busy(busy_a));
    uart_rx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16), .DIV_W(16)) u_p (
        .clk(clk), .reset(rst_v[1]), .cfg_div(cfg_div), .rx(rx_v[1]), .rd_if(if_p),
        .level(level_p), .overflow(ovf_p), .clear_ovf(clr_v[1]), .busy(busy_p));
    uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) u_f (
        .clk(clk), .reset(rst_v[2]), .cfg_div(cfg_div), .rx(rx_v[2]), .rd_if(if_f),
        .level(level_f), .overflow(ovf_f), .clear_ovf(clr_v[2]), .busy(busy_f));
    uart_rx_fifo #(.DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16), .DIV_W(16)) u_9 (
        .clk(clk), .reset(rst_v[3]), .cfg_div(cfg_div), .rx(rx_v[3]), .rd_if(if_9),
        .level(level_9), .overflow(ovf_9), .clear_ovf(clr_v[3]), .busy(busy_9));

    task automatic drive(input int ch, input logic v, input int n);
        rx_v[ch] = v;
        repeat (n) @(negedge clk);
    endtask

    // alt_div != 0 changes cfg_div right after the start bit.
    task automatic send_frame(input int ch, input logic [8:0] data, input int nbits,
                              input int has_par, input logic par_bit, input int nstop,
                              input int div, input int alt_div);
        cfg_div = div[15:0];
        drive(ch, 1'b0, div);
        if (alt_div != 0) cfg_div = alt_div[15:0];
        for (int i = 0; i < nbits; i++) drive(ch, data[i], div);
        if (has_par != 0) drive(ch, par_bit, div);
        for (int i = 0; i < nstop; i++) drive(ch, 1'b1, div);
        cfg_div = div[15:0];
    endtask

    task automatic test_reset();
        rst_v = 4'hF; rx_v = 4'hF; clr_v = 4'h0; cfg_div = 16'd104;
        if_a.rd_ready = 1'b0; if_p.rd_ready = 1'b0; if_f.rd_ready = 1'b0; if_9.rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_v = 4'h0;
        @(negedge clk);
        n_checks++; if (if_a.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", if_a.rd_valid); end
        n_checks++; if (if_a.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", if_a.rd_data); end
        n_checks++; if ({if_a.rd_perr, if_a.rd_ferr} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {if_a.rd_perr, if_a.rd_ferr}); end
        n_checks++; if (level_a !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level_a); end
        n_checks++; if ({ovf_a, busy_a} !== 2'b00) begin n_fail++; $display("FAIL reset_ovf_busy got=%b exp=00", {ovf_a, busy_a}); end
        n_checks++;
        if ({if_p.rd_valid, if_f.rd_valid, if_9.rd_valid, busy_p, busy_f, busy_9, ovf_p, ovf_f, ovf_9} !== 9'd0) begin
            n_fail++; $display("FAIL reset_others got=%b exp=0",
                {if_p.rd_valid, if_f.rd_valid, if_9.rd_valid, busy_p, busy_f, busy_9, ovf_p, ovf_f, ovf_9});
        end
    endtask

    task automatic test_8n1();
        int cyc;
        cyc = 0;
        fork
            send_frame(0, 9'h055, 8, 0, 1'b0, 1, 104, 0);
            begin
                while (if_a.rd_valid !== 1'b1 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
            end
        join
        n_checks++; if (cyc < 989 || cyc > 993) begin n_fail++; $display("FAIL 8n1_latency got=%0d exp=991+-2", cyc); end
        send_frame(0, 9'h0A3, 8, 0, 1'b0, 1, 104, 0);
        repeat (4) @(negedge clk);
        n_checks++; if (level_a !== 5'd2) begin n_fail++; $display("FAIL 8n1_level2 got=%0d exp=2", level_a); end
        n_checks++; if (if_a.rd_data !== 8'h55) begin n_fail++; $display("FAIL 8n1_data0 got=%h exp=55", if_a.rd_data); end
        n_checks++; if ({if_a.rd_perr, if_a.rd_ferr} !== 2'b00) begin n_fail++; $display("FAIL 8n1_flags0 got=%b exp=00", {if_a.rd_perr, if_a.rd_ferr}); end
        if_a.rd_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({if_a.rd_valid, if_a.rd_data} !== {1'b1, 8'hA3}) begin n_fail++; $display("FAIL 8n1_data1 got=%b/%h exp=1/a3", if_a.rd_valid, if_a.rd_data); end
        @(negedge clk);
        if_a.rd_ready = 1'b0;
        n_checks++; if (level_a !== 5'd0) begin n_fail++; $display("FAIL 8n1_level0 got=%0d exp=0", level_a); end
        n_checks++; if ({if_a.rd_valid, if_a.rd_data} !== 9'd0) begin n_fail++; $display("FAIL 8n1_empty got=%b/%h exp=0/00", if_a.rd_valid, if_a.rd_data); end
    endtask

    task automatic test_glitch();
        cfg_div = 16'd104;
        drive(0, 1'b0, 20);
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi got=%b exp=1", busy_a); end
        drive(0, 1'b1, 40);
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo got=%b exp=0", busy_a); end
        n_checks++; if (level_a !== 5'd0) begin n_fail++; $display("FAIL glitch_no_entry got=%0d exp=0", level_a); end
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 104, 0);
        repeat (4) @(negedge clk);
        n_checks++; if ({if_a.rd_valid, if_a.rd_data, if_a.rd_ferr} !== {1'b1, 8'h3C, 1'b0}) begin
            n_fail++; $display("FAIL glitch_next got=%b/%h/%b exp=1/3c/0", if_a.rd_valid, if_a.rd_data, if_a.rd_ferr); end
        if_a.rd_ready = 1'b1; @(negedge clk); if_a.rd_ready = 1'b0;
    endtask

    task automatic test_parity();
        send_frame(1, 9'h007, 8, 1, 1'b1, 1, 16, 0);
        send_frame(1, 9'h007, 8, 1, 1'b0, 1, 16, 0);
        repeat (4) @(negedge clk);
        n_checks++; if (level_p !== 5'd2) begin n_fail++; $display("FAIL par_level got=%0d exp=2", level_p); end
        n_checks++; if ({if_p.rd_data, if_p.rd_perr, if_p.rd_ferr} !== {8'h07, 2'b00}) begin
            n_fail++; $display("FAIL par_good got=%h/%b/%b exp=07/0/0", if_p.rd_data, if_p.rd_perr, if_p.rd_ferr); end
        if_p.rd_ready = 1'b1; @(negedge clk); if_p.rd_ready = 1'b0;
        n_checks++; if ({if_p.rd_data, if_p.rd_perr, if_p.rd_ferr} !== {8'h07, 2'b10}) begin
            n_fail++; $display("FAIL par_bad got=%h/%b/%b exp=07/1/0", if_p.rd_data, if_p.rd_perr, if_p.rd_ferr); end
        if_p.rd_ready = 1'b1; @(negedge clk); if_p.rd_ready = 1'b0;
    endtask

    task automatic test_break();
        cfg_div = 16'd16;
        drive(0, 1'b0, 480);
        drive(0, 1'b1, 40);
        n_checks++; if (level_a !== 5'd1) begin n_fail++; $display("FAIL brk_level got=%0d exp=1", level_a); end
        n_checks++; if ({if_a.rd_data, if_a.rd_perr, if_a.rd_ferr} !== {8'h00, 2'b01}) begin
            n_fail++; $display("FAIL brk_entry got=%h/%b/%b exp=00/0/1", if_a.rd_data, if_a.rd_perr, if_a.rd_ferr); end
        if_a.rd_ready = 1'b1; @(negedge clk); if_a.rd_ready = 1'b0;
        send_frame(0, 9'h081, 8, 0, 1'b0, 1, 16, 0);
        repeat (4) @(negedge clk);
        n_checks++; if ({level_a, if_a.rd_data, if_a.rd_ferr} !== {5'd1, 8'h81, 1'b0}) begin
            n_fail++; $display("FAIL brk_after got=%0d/%h/%b exp=1/81/0", level_a, if_a.rd_data, if_a.rd_ferr); end
        if_a.rd_ready = 1'b1; @(negedge clk); if_a.rd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int w;
        for (int k = 1; k <= 5; k++) send_frame(2, 9'(k), 8, 0, 1'b0, 1, 16, 0);
        repeat (4) @(negedge clk);
        n_checks++; if ({level_f, ovf_f} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL ovf_full got=%0d/%b exp=4/1", level_f, ovf_f); end
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (if_f.rd_data !== 8'(k)) begin n_fail++; $display("FAIL ovf_read%0d got=%h exp=%h", k, if_f.rd_data, 8'(k)); end
            if_f.rd_ready = 1'b1; @(negedge clk); if_f.rd_ready = 1'b0;
        end
        n_checks++; if ({level_f, ovf_f} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL ovf_sticky got=%0d/%b exp=0/1", level_f, ovf_f); end
        clr_v[2] = 1'b1; @(negedge clk); clr_v[2] = 1'b0;
        n_checks++; if (ovf_f !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", ovf_f); end
        for (int k = 0; k < 4; k++) send_frame(2, 9'(8'h11 + k), 8, 0, 1'b0, 1, 16, 0);
        w = 0;
        // Pop exactly in the push cycle, which is the first cycle busy is low again.
        fork
            send_frame(2, 9'h015, 8, 0, 1'b0, 1, 16, 0);
            begin
                while (busy_f !== 1'b1 && w < 400) begin @(negedge clk); w++; end
                while (busy_f !== 1'b0 && w < 400) begin @(negedge clk); w++; end
                if_f.rd_ready = 1'b1; @(negedge clk); if_f.rd_ready = 1'b0;
            end
        join
        n_checks++; if (w >= 400) begin n_fail++; $display("FAIL ovf_busy_timeout got=%0d exp=<400", w); end
        repeat (4) @(negedge clk);
        n_checks++; if ({level_f, ovf_f} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL ovf_poppush got=%0d/%b exp=4/0", level_f, ovf_f); end
        for (int k = 2; k <= 5; k++) begin
            n_checks++; if (if_f.rd_data !== 8'(8'h10 + k)) begin n_fail++; $display("FAIL ovf_drain%0d got=%h exp=%h", k, if_f.rd_data, 8'(8'h10 + k)); end
            if_f.rd_ready = 1'b1; @(negedge clk); if_f.rd_ready = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(3, 9'h0AA, 9, 0, 1'b0, 2, 16, 0);
        repeat (4) @(negedge clk);
        n_checks++; if (level_9 !== 5'd1) begin n_fail++; $display("FAIL mid_pre_level got=%0d exp=1", level_9); end
        drive(3, 1'b0, 16);
        drive(3, 1'b1, 16); drive(3, 1'b0, 16); drive(3, 1'b1, 16); drive(3, 1'b0, 16);
        drive(3, 1'b0, 8);
        n_checks++; if (busy_9 !== 1'b1) begin n_fail++; $display("FAIL mid_busy got=%b exp=1", busy_9); end
        rst_v[3] = 1'b1; rx_v[3] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({if_9.rd_valid, if_9.rd_data, if_9.rd_perr, if_9.rd_ferr, level_9, ovf_9, busy_9} !== 18'd0) begin
            n_fail++; $display("FAIL mid_reset got=%b/%h/%b/%b/%0d/%b/%b exp=all0", if_9.rd_valid, if_9.rd_data,
                               if_9.rd_perr, if_9.rd_ferr, level_9, ovf_9, busy_9); end
        rst_v[3] = 1'b0;
        drive(3, 1'b1, 192);
        send_frame(3, 9'h1A5, 9, 0, 1'b0, 2, 16, 40);
        repeat (4) @(negedge clk);
        n_checks++; if ({level_9, if_9.rd_data, if_9.rd_perr, if_9.rd_ferr} !== {5'd1, 9'h1A5, 2'b00}) begin
            n_fail++; $display("FAIL mid_after got=%0d/%h/%b/%b exp=1/1a5/0/0", level_9, if_9.rd_data, if_9.rd_perr, if_9.rd_ferr); end
        if_9.rd_ready = 1'b1; @(negedge clk); if_9.rd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_glitch();
        test_parity();
        test_break();
        test_overflow();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
